seg_595_rx: RTL and testbench
=============================

# seg_595_rx

Receive-side counterpart of the dynamic-scan 74HC595 seven-segment driver. It samples the serial shift-register pins (`shcp`, `stcp`, `ds`, `oe`) with `sys_clk` and reconstructs the 14-bit word that a 595 chain would present on its parallel outputs. Each latched segment pattern is stored into a six-digit frame buffer keyed by the one-hot digit select. It sits in the verification and self-test path: it monitors the display driver's pins and reports what the panel is showing.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on all four input pins; legal range 2..3.
- `sys_clk` in 1: system clock; every flop in the block runs on it.
- `sys_rst` in 1: reset, synchronous, active-high.
- `shcp` in 1: shift clock pin; `ds` is captured on its rising edge.
- `stcp` in 1: storage/latch clock pin; the shift register is copied to the output register on its rising edge.
- `ds` in 1: serial data pin.
- `oe` in 1: output enable pin, active-low.
- `seg_q` out 8: latched segment byte {dp,g,f,e,d,c,b,a}, active-low.
- `sel_q` out 6: latched digit select, active-high.
- `out_en` out 1: synchronized, inverted `oe`; 1 means the panel is driven.
- `latch_pulse` out 1: one-cycle strobe when `seg_q`/`sel_q` update.
- `digit_seg` out 48: frame buffer; bits [8i+7:8i] hold the pattern of digit i.
- `frame_done` out 1: one-cycle strobe when all 6 digits have been refreshed since the previous strobe.
- `len_err` out 1: one-cycle strobe when a latch occurs and the shift count is not 14.
- `sel_err` out 1: one-cycle strobe when the latched `sel_q` is not one-hot.
- `digit_val` out 24: decoded hex value per digit, 4 bits each (see Configuration).
- `digit_ok` out 6: decode-valid flag per digit.

## Operation
- Input conditioning:
  - All pins pass through a `SYNC_STAGES`-deep flop chain, followed by one history flop.
  - An edge is detected when the synchronized level is 1 and the history flop is 0.
  - Because `ds` is delayed identically to `shcp`, `ds` is sampled on the same cycle the `shcp` rise is detected.
- Shift path:
  - On each `shcp` rise, the 14-bit shift register takes `sr <= {sr[12:0], ds}`.
  - The bit counter `bcnt` (4 bits) increments and saturates at 15.
- Bit mapping after 14 shifts:
  - The first received bit lands in sr[13], the last in sr[0].
  - seg = sr[13:6] (first bit = seg[0], eighth bit = seg[7]).
  - sel = sr[5:0] (ninth bit = sel[5], last bit = sel[0]).
- Latch (on `stcp` rise):
  - `seg_q`/`sel_q` load from `sr`, and `latch_pulse` = 1.
  - `len_err` = (bcnt != 14); `bcnt` clears.
  - The latch is always performed, including on a length error.
- Simultaneous `shcp` and `stcp` rise in the same cycle: the shift happens first. The latch takes the post-shift value, and `bcnt` clears to 0.
- Frame buffer (cycle after `latch_pulse`):
  - If `sel_q` is one-hot with bit i set, write `digit_seg[i] <= seg_q` and set `upd_mask[i]`.
  - Otherwise `sel_err` = 1 and neither buffer nor mask changes.
  - When `upd_mask` including the current write equals 6'b111111: `frame_done` = 1 and the mask clears.
- `out_en` only reports pin state. It never gates the capture path.
- Reset mid-word discards the partial word; the next word starts from `bcnt` = 0.

## Timing
- Reset values:
  - `seg_q` = 8'hFF, `sel_q` = 0, `digit_seg` = all 8'hFF.
  - `out_en`, `latch_pulse`, `frame_done`, `len_err`, `sel_err` = 0.
  - `digit_val` = 0, `digit_ok` = 0; `sr`, `bcnt` and `upd_mask` = 0.
- Pin timing: `shcp` and `stcp` must each stay high and low for at least 2 `sys_clk` cycles. `ds` must be stable from 1 cycle before to 1 cycle after the `shcp` rise.
- Latency, with `stcp` first sampled high at clock edge N:
  - `seg_q`/`sel_q`/`latch_pulse`/`len_err` update at edge N+SYNC_STAGES+1.
  - `digit_seg`/`frame_done`/`sel_err` update one edge later.
  - `digit_val`/`digit_ok` update one edge after `digit_seg`.
- All strobes are exactly one cycle wide. Back-to-back latches are processed without loss.

## Configuration
- `SEG595_RX_DECODE_EN` defined:
  - Registered decoder per digit, ignoring dp (bit 7).
  - Patterns C0/F9/A4/B0/99/92/82/F8/80/90 decode to 0..9, with `digit_ok` = 1.
  - Any other pattern, including blank 0xFF and minus 0xBF, gives value 0 with `digit_ok` = 0.
- Not defined: `digit_val` and `digit_ok` are tied to 0 and the decoder logic is absent.

## Test plan
- Reset: assert `sys_rst` for 3 cycles -> every output equals its reset value and `digit_seg` = 48'hFFFF_FFFF_FFFF.
- Single word: shift seg=8'hC0, sel=6'b000001 (14 bits, phase 2 cycles), then pulse `stcp` -> `seg_q`=C0, `sel_q`=01, `latch_pulse` 1 cycle, `len_err`=0, then `digit_seg[7:0]`=C0. With the macro, `digit_val[3:0]`=0 and `digit_ok[0]`=1.
- Full frame: six words with sel 01,02,04,08,10,20 and seg F9,A4,B0,99,92,82 -> exactly one `frame_done`, on the sixth buffer write. With the macro, `digit_val` = 24'h654321.
- Length error: 13 shifts, then `stcp` -> `len_err`=1 and the latch still occurs. A following correct 14-bit word gives `len_err`=0.
- Select error: sel=6'b000011 -> `sel_err`=1, `digit_seg` unchanged, no `frame_done`.
- Reset mid-word: assert `sys_rst` after 7 shifts, then send a full valid word -> correct `seg_q`/`sel_q` and `len_err`=0.

Source files
------------

// File: rtl/seg_595_rx_if.sv
// seg_595_rx_if
// Pin bundle of a 74HC595 seven-segment chain as seen by a monitor.
//   shcp : shift clock, ds captured on its rising edge
//   stcp : storage clock, shift register copied to outputs on its rising edge
//   ds   : serial data
//   oe   : output enable, active-low
// master : the side that drives the pins (display driver or bench)
// slave  : the side that only observes them (seg_595_rx)
interface seg_595_rx_if;
    logic shcp;
    logic stcp;
    logic ds;
    logic oe;

    modport master (output shcp, output stcp, output ds, output oe);
    modport slave  (input  shcp, input  stcp, input  ds, input  oe);
endinterface

// File: rtl/seg_595_rx.sv
// seg_595_rx
// Observes the pins of a dynamic-scan 74HC595 seven-segment driver and
// rebuilds what the panel shows: the latched 14-bit word, a six-digit frame
// buffer keyed by the one-hot digit select, and framing/error strobes.
//
// Parameters:
//   SYNC_STAGES : synchronizer depth on every pin (2..3)
// Ports:
//   sys_clk, sys_rst   : clock, synchronous active-high reset
//   pins (slave)       : shcp, stcp, ds, oe pins of the 595 chain
//   seg_q, sel_q       : latched segment byte (active-low) and digit select
//   out_en             : synchronized inverted oe
//   latch_pulse        : strobe when seg_q/sel_q update
//   len_err            : strobe when a latch follows a shift count other than 14
//   digit_seg          : frame buffer, digit i at [8i+7:8i]
//   frame_done         : strobe when all six digits were refreshed
//   sel_err            : strobe when a latched select is not one-hot
//   digit_val/digit_ok : per-digit decoded hex value and valid flag
// Build option:
//   SEG595_RX_DECODE_EN : when defined, adds the registered 7-segment decoder;
//                         otherwise digit_val/digit_ok are tied to zero.
module seg_595_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    seg_595_rx_if.slave  pins,
    output logic [7:0]   seg_q,
    output logic [5:0]   sel_q,
    output logic         out_en,
    output logic         latch_pulse,
    output logic [47:0]  digit_seg,
    output logic         frame_done,
    output logic         len_err,
    output logic         sel_err,
    output logic [23:0]  digit_val,
    output logic [5:0]   digit_ok
);

    // Pin vector order {oe, ds, stcp, shcp}; oe idles high (panel dark).
    localparam logic [3:0] PIN_IDLE = 4'b1000;

    logic [3:0]  pin_raw;
    logic [3:0]  sync_q [SYNC_STAGES];
    logic [3:0]  pin_s;
    logic [1:0]  hist_q;
    logic        shcp_rise;
    logic        stcp_rise;
    logic        ds_s;
    logic        oe_s;

    logic [13:0] sr;
    logic [13:0] sr_next;
    logic [3:0]  bcnt;
    logic [3:0]  bcnt_next;
    logic        cap_vld;
    logic [13:0] cap_word;
    logic        cap_len_err;
    logic [7:0]  cap_seg;

    logic [5:0]  upd_mask;
    logic [5:0]  mask_next;
    logic        sel_onehot;

    assign pin_raw = {pins.oe, pins.ds, pins.stcp, pins.shcp};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PIN_IDLE;
            hist_q <= 2'b00;
        end else begin
            sync_q[0] <= pin_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            hist_q <= sync_q[SYNC_STAGES-1][1:0];
        end
    end

    assign pin_s     = sync_q[SYNC_STAGES-1];
    assign shcp_rise = pin_s[0] & ~hist_q[0];
    assign stcp_rise = pin_s[1] & ~hist_q[1];
    // ds travels through the same chain as shcp, so it is aligned with the rise.
    assign ds_s      = pin_s[2];
    assign oe_s      = pin_s[3];

    // A shift in the same cycle as a latch is applied first, so the latch
    // and the length check both see the post-shift state.
    always_comb begin
        sr_next   = sr;
        bcnt_next = bcnt;
        if (shcp_rise) begin
            sr_next = {sr[12:0], ds_s};
            if (bcnt != 4'd15) bcnt_next = bcnt + 4'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sr          <= '0;
            bcnt        <= '0;
            cap_vld     <= 1'b0;
            cap_word    <= '0;
            cap_len_err <= 1'b0;
        end else begin
            sr      <= sr_next;
            cap_vld <= stcp_rise;
            if (stcp_rise) begin
                cap_word    <= sr_next;
                cap_len_err <= (bcnt_next != 4'd14);
                bcnt        <= '0;
            end else begin
                bcnt <= bcnt_next;
            end
        end
    end

    // The driver shifts the segment byte LSB first, so the first bit (sr[13])
    // is seg[0]; the select follows MSB first and lands unreversed in sr[5:0].
    always_comb begin
        cap_seg = '0;
        for (int k = 0; k < 8; k++) cap_seg[k] = cap_word[13-k];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            seg_q       <= 8'hFF;
            sel_q       <= '0;
            latch_pulse <= 1'b0;
            len_err     <= 1'b0;
            out_en      <= 1'b0;
        end else begin
            latch_pulse <= cap_vld;
            len_err     <= cap_vld & cap_len_err;
            out_en      <= ~oe_s;
            if (cap_vld) begin
                seg_q <= cap_seg;
                sel_q <= cap_word[5:0];
            end
        end
    end

    assign sel_onehot = (sel_q != 6'd0) && ((sel_q & (sel_q - 6'd1)) == 6'd0);
    assign mask_next  = upd_mask | sel_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            digit_seg  <= {6{8'hFF}};
            upd_mask   <= '0;
            frame_done <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sel_err    <= 1'b0;
            if (latch_pulse) begin
                if (sel_onehot) begin
                    for (int i = 0; i < 6; i++) begin
                        if (sel_q[i]) digit_seg[8*i +: 8] <= seg_q;
                    end
                    if (mask_next == 6'h3F) begin
                        frame_done <= 1'b1;
                        upd_mask   <= '0;
                    end else begin
                        upd_mask <= mask_next;
                    end
                end else begin
                    sel_err <= 1'b1;
                end
            end
        end
    end

`ifdef SEG595_RX_DECODE_EN
    // Decimal-point bit is ignored; returns {ok, value}.
    function automatic logic [4:0] decode_digit(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = {1'b1, 4'd0};
            7'h79:   r = {1'b1, 4'd1};
            7'h24:   r = {1'b1, 4'd2};
            7'h30:   r = {1'b1, 4'd3};
            7'h19:   r = {1'b1, 4'd4};
            7'h12:   r = {1'b1, 4'd5};
            7'h02:   r = {1'b1, 4'd6};
            7'h78:   r = {1'b1, 4'd7};
            7'h00:   r = {1'b1, 4'd8};
            7'h10:   r = {1'b1, 4'd9};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            digit_val <= '0;
            digit_ok  <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                {digit_ok[i], digit_val[4*i +: 4]} <= decode_digit(digit_seg[8*i +: 7]);
            end
        end
    end
`else
    assign digit_val = '0;
    assign digit_ok  = '0;
`endif

endmodule

// File: tb/tb_seg_595_rx.sv
`timescale 1ns/1ps
module tb_seg_595_rx;
    localparam int SYNC = 2;
    localparam int MAXC = 32768;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  seg_q;
    logic [5:0]  sel_q;
    logic        out_en, latch_pulse, frame_done, len_err, sel_err;
    logic [47:0] digit_seg;
    logic [23:0] digit_val;
    logic [5:0]  digit_ok;

    seg_595_rx_if pins();

    seg_595_rx #(.SYNC_STAGES(SYNC)) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .pins(pins),
        .seg_q(seg_q), .sel_q(sel_q), .out_en(out_en), .latch_pulse(latch_pulse),
        .digit_seg(digit_seg), .frame_done(frame_done), .len_err(len_err),
        .sel_err(sel_err), .digit_val(digit_val), .digit_ok(digit_ok)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Per-cycle record of pin inputs and scheduled latch results.
    bit         rst_at   [MAXC];
    bit         oe_at    [MAXC];
    bit         ev_latch [MAXC];
    logic [7:0] ev_seg   [MAXC];
    logic [5:0] ev_sel   [MAXC];
    bit         ev_len   [MAXC];

    // Stimulus-side knowledge of the word being shifted.
    logic [13:0] b_sr = '0;
    int          b_cnt = 0;

    // Model of the outputs.
    logic [7:0]  m_seg;
    logic [5:0]  m_sel;
    logic        m_lp, m_len, m_fd, m_se;
    logic [7:0]  m_digit [6];
    logic [5:0]  m_mask;
    logic [23:0] m_val;
    logic [5:0]  m_ok;

    int cnt_lp = 0, cnt_fd = 0, cnt_le = 0, cnt_se = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [4:0] dec(input logic [7:0] p);
        logic [7:0] tbl [10];
        logic [4:0] r;
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        r = 5'd0;
        for (int k = 0; k < 10; k++)
            if (p[6:0] == tbl[k][6:0]) r = {1'b1, 4'(k)};
        return r;
    endfunction

    function automatic logic [47:0] pack_digits();
        logic [47:0] v;
        for (int i = 0; i < 6; i++) v[8*i +: 8] = m_digit[i];
        return v;
    endfunction

    task automatic model_reset();
        m_seg = 8'hFF; m_sel = '0; m_lp = 0; m_len = 0; m_fd = 0; m_se = 0;
        for (int i = 0; i < 6; i++) m_digit[i] = 8'hFF;
        m_mask = '0; m_val = '0; m_ok = '0;
    endtask

    task automatic model_step(input int c);
        logic [5:0] s;
        logic [4:0] d;
        if (rst_at[c]) begin
            model_reset();
        end else begin
            for (int i = 0; i < 6; i++) begin
                d = dec(m_digit[i]);
`ifdef SEG595_RX_DECODE_EN
                m_ok[i] = d[4];
                m_val[4*i +: 4] = d[3:0];
`else
                m_ok[i] = 1'b0;
                m_val[4*i +: 4] = 4'd0;
`endif
            end
            m_lp  = ev_latch[c];
            m_len = ev_latch[c] && ev_len[c];
            if (ev_latch[c]) begin
                m_seg = ev_seg[c];
                m_sel = ev_sel[c];
            end
            m_fd = 0;
            m_se = 0;
            if (ev_latch[c-1]) begin
                s = ev_sel[c-1];
                if ($countones(s) == 1) begin
                    for (int i = 0; i < 6; i++) if (s[i]) m_digit[i] = ev_seg[c-1];
                    m_mask = m_mask | s;
                    if (m_mask == 6'h3F) begin
                        m_fd = 1;
                        m_mask = '0;
                    end
                end else begin
                    m_se = 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (cyc < MAXC) begin
            rst_at[cyc] = sys_rst;
            oe_at[cyc]  = pins.oe;
        end
    end

    always @(negedge clk) begin
        int c;
        c = cyc;
        if (c >= 1 && c < MAXC) begin
            model_step(c);
            chk("seg_q", 48'(seg_q), 48'(m_seg));
            chk("sel_q", 48'(sel_q), 48'(m_sel));
            chk("latch_pulse", 48'(latch_pulse), 48'(m_lp));
            chk("len_err", 48'(len_err), 48'(m_len));
            chk("digit_seg", digit_seg, pack_digits());
            chk("frame_done", 48'(frame_done), 48'(m_fd));
            chk("sel_err", 48'(sel_err), 48'(m_se));
            chk("digit_val", 48'(digit_val), 48'(m_val));
            chk("digit_ok", 48'(digit_ok), 48'(m_ok));
            if (c >= 3 && !rst_at[c] && !rst_at[c-1] && !rst_at[c-2])
                chk("out_en", 48'(out_en), 48'(!oe_at[c-2]));
            cnt_lp += int'(latch_pulse);
            cnt_fd += int'(frame_done);
            cnt_le += int'(len_err);
            cnt_se += int'(sel_err);
        end
    end

    // Called at a negedge just before stcp goes high; the edge N is the next
    // posedge and the latched word is visible after edge N+SYNC+1.
    task automatic sched_latch();
        int n;
        n = cyc + 1 + SYNC + 1;
        pins.stcp = 1'b1;
        if (n < MAXC) begin
            ev_latch[n] = 1;
            ev_sel[n]   = b_sr[5:0];
            for (int k = 0; k < 8; k++) ev_seg[n][k] = b_sr[13-k];
            ev_len[n]   = (b_cnt != 14);
        end
        b_cnt = 0;
    endtask

    task automatic put_bit(input bit b, input bit with_latch);
        @(negedge clk); pins.ds = b;
        @(negedge clk); pins.shcp = 1'b1;
        b_sr = {b_sr[12:0], b};
        if (b_cnt < 15) b_cnt++;
        if (with_latch) sched_latch();
        @(negedge clk);
        @(negedge clk); pins.shcp = 1'b0; pins.stcp = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_latch();
        @(negedge clk); sched_latch();
        @(negedge clk);
        @(negedge clk); pins.stcp = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] seg, input logic [5:0] sel,
                             input int nbits, input bit simul);
        logic [13:0] seq;
        bit b;
        for (int k = 0; k < 8; k++) seq[13-k] = seg[k];
        seq[5:0] = sel;
        for (int i = 0; i < nbits; i++) begin
            b = (i < 14) ? seq[13-i] : 1'($urandom % 2);
            put_bit(b, simul && (i == nbits - 1));
        end
        if (!simul || nbits == 0) do_latch();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk); sys_rst = 1'b1;
        b_sr = '0; b_cnt = 0;
        repeat (n) @(negedge clk);
        sys_rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int lp0, fd0, le0, se0, nb, k;
        logic [7:0] sg;
        logic [5:0] sl;
        logic [7:0] tbl [10];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        model_reset();
        pins.shcp = 0; pins.stcp = 0; pins.ds = 0; pins.oe = 1;

        // Reset values
        do_reset(3);
        idle(2);
        chk("rst seg_q", 48'(seg_q), 48'hFF);
        chk("rst sel_q", 48'(sel_q), 48'h0);
        chk("rst digit_seg", digit_seg, 48'hFFFF_FFFF_FFFF);
        chk("rst out_en", 48'(out_en), 48'h0);
        chk("rst digit_ok", 48'(digit_ok), 48'h0);

        // Single word
        pins.oe = 0;
        lp0 = cnt_lp; le0 = cnt_le;
        send_word(8'hC0, 6'b000001, 14, 0);
        idle(4);
        chk("single seg_q", 48'(seg_q), 48'hC0);
        chk("single sel_q", 48'(sel_q), 48'h01);
        chk("single latch count", 48'(cnt_lp - lp0), 48'd1);
        chk("single len_err count", 48'(cnt_le - le0), 48'd0);
        chk("single digit0", 48'(digit_seg[7:0]), 48'hC0);
        chk("single out_en", 48'(out_en), 48'h1);
`ifdef SEG595_RX_DECODE_EN
        chk("single digit_val0", 48'(digit_val[3:0]), 48'h0);
        chk("single digit_ok0", 48'(digit_ok[0]), 48'h1);
`endif

        // Full frame
        fd0 = cnt_fd;
        send_word(8'hF9, 6'h01, 14, 0);
        send_word(8'hA4, 6'h02, 14, 0);
        send_word(8'hB0, 6'h04, 14, 0);
        send_word(8'h99, 6'h08, 14, 0);
        send_word(8'h92, 6'h10, 14, 0);
        chk("frame early done", 48'(cnt_fd - fd0), 48'd0);
        send_word(8'h82, 6'h20, 14, 0);
        idle(4);
        chk("frame done count", 48'(cnt_fd - fd0), 48'd1);
        chk("frame digit_seg", digit_seg, 48'h82_92_99_B0_A4_F9);
`ifdef SEG595_RX_DECODE_EN
        chk("frame digit_val", 48'(digit_val), 48'h654321);
        chk("frame digit_ok", 48'(digit_ok), 48'h3F);
`endif

        // Length error: 13 bits leave the last word's sel[0] in sr[13]
        lp0 = cnt_lp; le0 = cnt_le;
        send_word(8'hFF, 6'h01, 13, 0);
        idle(2);
        chk("lenerr count", 48'(cnt_le - le0), 48'd1);
        chk("lenerr latch count", 48'(cnt_lp - lp0), 48'd1);
        chk("lenerr seg_q", 48'(seg_q), 48'hFE);
        chk("lenerr sel_q", 48'(sel_q), 48'h20);
        le0 = cnt_le;
        send_word(8'hC0, 6'h02, 14, 0);
        idle(2);
        chk("after lenerr count", 48'(cnt_le - le0), 48'd0);
        chk("after lenerr seg_q", 48'(seg_q), 48'hC0);

        // Select error
        se0 = cnt_se; fd0 = cnt_fd;
        send_word(8'h80, 6'b000011, 14, 0);
        idle(3);
        chk("selerr count", 48'(cnt_se - se0), 48'd1);
        chk("selerr frame_done", 48'(cnt_fd - fd0), 48'd0);
        chk("selerr digit_seg", digit_seg, 48'hFE_92_99_B0_C0_F9);

        // Shift and latch on the same cycle
        le0 = cnt_le;
        send_word(8'hA4, 6'h04, 14, 1);
        idle(4);
        chk("simul seg_q", 48'(seg_q), 48'hA4);
        chk("simul sel_q", 48'(sel_q), 48'h04);
        chk("simul len_err", 48'(cnt_le - le0), 48'd0);

        // Reset mid-word
        for (int i = 0; i < 7; i++) put_bit(1'b1, 0);
        do_reset(2);
        idle(2);
        le0 = cnt_le;
        send_word(8'h99, 6'h08, 14, 0);
        idle(2);
        chk("midrst seg_q", 48'(seg_q), 48'h99);
        chk("midrst sel_q", 48'(sel_q), 48'h08);
        chk("midrst len_err", 48'(cnt_le - le0), 48'd0);

        // Randomized traffic
        for (int w = 0; w < 50; w++) begin
            if ($urandom_range(0, 9) == 0) pins.oe = 1'($urandom % 2);
            k  = $urandom_range(0, 9);
            sg = (k < 7) ? tbl[$urandom_range(0, 9)] : 8'($urandom);
            sl = ($urandom_range(0, 9) < 7) ? 6'(1 << $urandom_range(0, 5)) : 6'($urandom);
            k  = $urandom_range(0, 19);
            if (k < 15)      nb = 14;
            else if (k == 15) nb = 0;
            else             nb = $urandom_range(11, 16);
            if ($urandom_range(0, 19) == 0) begin
                for (int i = 0; i < $urandom_range(1, 12); i++) put_bit(1'($urandom % 2), 0);
                do_reset($urandom_range(1, 3));
            end
            send_word(sg, sl, nb, ($urandom_range(0, 4) == 0) && nb > 0);
        end
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
